// File: rtl/tile_pixel_pipe.sv
// tile_pixel_pipe: scrolled tile-map -> sprite-ROM -> palette pixel pipeline.
// Fixed latency of 3 + ROM_LAT clocks from x/y/vde/sync_in to R/G/B/de_out/sync_out.
// The map RAM is read with one cycle latency and the sprite ROM with ROM_LAT
// cycles; the column, inside and sync sideband travel alongside so that every
// stage sees data belonging to the same pixel.
module tile_pixel_pipe #(
   parameter int H_START       = 192,
   parameter int V_START       = 41,
   parameter int WIDTH         = 1920,
   parameter int HEIGHT        = 1080,
   parameter int TILE_LOG2     = 5,
   parameter int IDX_W         = 4,
   parameter int PIX_W         = 3,
   parameter int MAP_COLS_LOG2 = 6,
   parameter int MAP_ROWS_LOG2 = 5,
   parameter int ROM_LAT       = 1
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [11:0]                            x,
   input  logic [11:0]                            y,
   input  logic                                   vde,
   input  logic [1:0]                             sync_in,
   input  logic                                   frame_start,
   input  logic [11:0]                            scroll_x,
   input  logic [11:0]                            scroll_y,
   output logic [MAP_COLS_LOG2+MAP_ROWS_LOG2-1:0] map_addr,
   input  logic [IDX_W-1:0]                       map_data,
   output logic [IDX_W+TILE_LOG2-1:0]             rom_addr,
   input  logic [(PIX_W<<TILE_LOG2)-1:0]          rom_data,
   input  logic                                   pal_we,
   input  logic [PIX_W-1:0]                       pal_addr,
   input  logic [23:0]                            pal_wdata,
   output logic [7:0]                             R,
   output logic [7:0]                             G,
   output logic [7:0]                             B,
   output logic                                   de_out,
   output logic [1:0]                             sync_out
);

   localparam int LX_W  = MAP_COLS_LOG2 + TILE_LOG2;
   localparam int LY_W  = MAP_ROWS_LOG2 + TILE_LOG2;
   localparam int PAL_N = 1 << PIX_W;

   // Power-up palette: white background, then blue, green, black, red.
   function automatic logic [23:0] pal_reset_value(input int idx);
      logic [23:0] v;
      case (idx)
         0:       v = 24'hFFFFFF;
         1:       v = 24'h0000FF;
         2:       v = 24'h00FF00;
         3:       v = 24'h000000;
         4:       v = 24'hFF0000;
         default: v = 24'h000000;
      endcase
      return v;
   endfunction

   // ---------------------------------------------------------------- shadows
   logic [11:0] sx_r;
   logic [11:0] sy_r;

   // Scroll shadows load only on frame_start so a whole frame scrolls as a unit.
   always_ff @(posedge clk) begin
      if (rst) begin
         sx_r <= 12'd0;
         sy_r <= 12'd0;
      end else if (frame_start) begin
         sx_r <= scroll_x;
         sy_r <= scroll_y;
      end else begin
         sx_r <= sx_r;
         sy_r <= sy_r;
      end
   end

   // --------------------------------------------------------------- stage S0
   logic [11:0]     dx_s;
   logic [11:0]     dy_s;
   logic [LX_W-1:0] lx_s;
   logic [LY_W-1:0] ly_s;
   logic            inside_s;

   // Screen-relative and map-relative coordinates; the map wraps by truncation.
   always_comb begin
      dx_s     = x - 12'(H_START);
      dy_s     = y - 12'(V_START);
      lx_s     = LX_W'(dx_s + sx_r);
      ly_s     = LY_W'(dy_s + sy_r);
      inside_s = vde && (dx_s < 12'(WIDTH)) && (dy_s < 12'(HEIGHT));
   end

   logic [TILE_LOG2-1:0] col1_r;
   logic [TILE_LOG2-1:0] row1_r;
   logic                 de1_r;
   logic                 in1_r;
   logic [1:0]           sync1_r;

   // S0 register: map address plus the in-tile position and sideband.
   always_ff @(posedge clk) begin
      if (rst) begin
         map_addr <= {(MAP_COLS_LOG2+MAP_ROWS_LOG2){1'b0}};
         col1_r   <= {TILE_LOG2{1'b0}};
         row1_r   <= {TILE_LOG2{1'b0}};
         de1_r    <= 1'b0;
         in1_r    <= 1'b0;
         sync1_r  <= 2'b00;
      end else begin
         map_addr <= {ly_s[LY_W-1:TILE_LOG2], lx_s[LX_W-1:TILE_LOG2]};
         col1_r   <= lx_s[TILE_LOG2-1:0];
         row1_r   <= ly_s[TILE_LOG2-1:0];
         de1_r    <= vde;
         in1_r    <= inside_s;
         sync1_r  <= sync_in;
      end
   end

   // ------------------------------------------- map wait and ROM wait stages
   // Index 0 lines up with map_data; index ROM_LAT lines up with rom_data.
   logic [TILE_LOG2-1:0] row2_r;
   logic [TILE_LOG2-1:0] col_d_r  [0:ROM_LAT];
   logic                 de_d_r   [0:ROM_LAT];
   logic                 in_d_r   [0:ROM_LAT];
   logic [1:0]           sync_d_r [0:ROM_LAT];

   // Sideband delay line covering the map read and the sprite ROM latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         row2_r <= {TILE_LOG2{1'b0}};
         for (int i = 0; i <= ROM_LAT; i++) begin
            col_d_r[i]  <= {TILE_LOG2{1'b0}};
            de_d_r[i]   <= 1'b0;
            in_d_r[i]   <= 1'b0;
            sync_d_r[i] <= 2'b00;
         end
      end else begin
         row2_r      <= row1_r;
         col_d_r[0]  <= col1_r;
         de_d_r[0]   <= de1_r;
         in_d_r[0]   <= in1_r;
         sync_d_r[0] <= sync1_r;
         for (int i = 1; i <= ROM_LAT; i++) begin
            col_d_r[i]  <= col_d_r[i-1];
            de_d_r[i]   <= de_d_r[i-1];
            in_d_r[i]   <= in_d_r[i-1];
            sync_d_r[i] <= sync_d_r[i-1];
         end
      end
   end

   // Sprite ROM address is formed straight from the returning tile index.
   always_comb begin
      rom_addr = {map_data, row2_r};
   end

   // ---------------------------------------------------- pixel and palette
   logic [23:0]          pal_r [0:PAL_N-1];
   logic [TILE_LOG2-1:0] col_rev_s;
   logic [31:0]          shamt_s;
   logic [PIX_W-1:0]     pix_s;
   logic [23:0]          colour_s;

   // Leftmost pixel sits in the top bits, so column c is slot (2^T-1-c) = ~c.
   always_comb begin
      col_rev_s = ~col_d_r[ROM_LAT];
      shamt_s   = 32'(col_rev_s) * 32'(PIX_W);
      pix_s     = PIX_W'(rom_data >> shamt_s);
      colour_s  = pal_r[pix_s];
   end

   // Palette storage: writes land on the clock edge, reads in that cycle see the old entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PAL_N; i++) begin
            pal_r[i] <= pal_reset_value(i);
         end
      end else if (pal_we) begin
         pal_r[pal_addr] <= pal_wdata;
      end else begin
         pal_r[pal_addr] <= pal_r[pal_addr];
      end
   end

   // Output register: black outside the active window, palette colour inside.
   always_ff @(posedge clk) begin
      if (rst) begin
         R        <= 8'd0;
         G        <= 8'd0;
         B        <= 8'd0;
         de_out   <= 1'b0;
         sync_out <= 2'b00;
      end else begin
         if (in_d_r[ROM_LAT]) begin
            {R, G, B} <= colour_s;
         end else begin
            {R, G, B} <= 24'd0;
         end
         de_out   <= de_d_r[ROM_LAT];
         sync_out <= sync_d_r[ROM_LAT];
      end
   end

endmodule

// File: doc/tile_pixel_pipe.md
# tile_pixel_pipe

Parametrised, pipelined successor to the single-layer sprite pixel generator. It maps the raw video timing counters (x, y, vde) to a scrolled tile-map lookup, a tile-sprite ROM fetch and a programmable palette. It emits registered RGB with a fixed, documented latency and a delayed sync/DE sideband, so sync-read memories stay aligned with the video timing. It sits between the video timing generator and the TMDS/VGA output stage.

## Interface
- H_START, 192: x value of first active pixel (sync + back porch + border)
- V_START, 41: y value of first active line
- WIDTH, 1920: active pixels per line
- HEIGHT, 1080: active lines
- TILE_LOG2, 5: log2 tile edge in pixels (32×32)
- IDX_W, 4: tile/sprite index width
- PIX_W, 3: bits per sprite pixel; palette has 2^PIX_W entries
- MAP_COLS_LOG2, 6: log2 tile-map columns (64)
- MAP_ROWS_LOG2, 5: log2 tile-map rows (32)
- ROM_LAT, 1: sprite ROM read latency in cycles (≥1)
- clk  in  1  pixel clock, sole clock
- rst  in  1  synchronous, active-high reset
- x, y  in  12 each  raw timing counters
- vde  in  1  video data enable for the current x/y
- sync_in  in  2  {vsync, hsync} aligned with x/y
- frame_start  in  1  one-cycle pulse; latches scroll shadows
- scroll_x, scroll_y  in  12 each  scroll offsets in pixels
- map_addr  out  MAP_COLS_LOG2+MAP_ROWS_LOG2  tile-map read address (registered)
- map_data  in  IDX_W  tile index; valid exactly 1 cycle after map_addr
- rom_addr  out  IDX_W+TILE_LOG2  sprite ROM address {index, row-in-tile}
- rom_data  in  PIX_W<<TILE_LOG2  one sprite row; valid ROM_LAT cycles after rom_addr
- pal_we  in  1  palette write strobe
- pal_addr  in  PIX_W  palette entry
- pal_wdata  in  24  {R,G,B}
- R, G, B  out  8 each  registered pixel colour
- de_out  out  1  delayed vde
- sync_out  out  2  delayed sync_in

## Operation
- Scroll shadows sx/sy load scroll_x/scroll_y only on a frame_start cycle. Mid-frame scroll changes do not affect the frame in progress.
- S0 (cycle t): lx = (x − H_START + sx) mod 2^(MAP_COLS_LOG2+TILE_LOG2); ly = (y − V_START + sy) mod 2^(MAP_ROWS_LOG2+TILE_LOG2). Arithmetic is 12-bit with truncation; the wrap comes from the modulo.
- S0 also computes inside = vde && (x − H_START) < WIDTH && (y − V_START) < HEIGHT.
- S0 registers map_addr = {ly>>TILE_LOG2, lx>>TILE_LOG2}, i.e. row·2^MAP_COLS_LOG2 + col.
- S0 delays the column-in-tile (lx low bits) and row-in-tile (ly low bits) through the pipeline.
- At t+2, rom_addr = {map_data, row-in-tile}, driven combinationally from map_data and the delayed row.
- At t+2+ROM_LAT: pixel p = rom_data[(2^TILE_LOG2−1−col)·PIX_W +: PIX_W]. The leftmost pixel occupies the top bits.
- Output register:
  - not inside → RGB = 0
  - p == 0 → palette[0] (background, transparent)
  - otherwise → palette[p]
- Palette reset contents: [0]=FFFFFF, [1]=0000FF, [2]=00FF00, [3]=000000, [4]=FF0000, [5..]=000000.
- Palette writes take effect the cycle after pal_we. A read of the same entry in the write cycle returns the old value. Writes are not shadowed.
- The vde/inside/sync sideband is delayed through the same stages as the pixel data.

## Timing
- Latency L = 3 + ROM_LAT cycles (4 by default) from x/y/vde/sync_in to R/G/B/de_out/sync_out.
- Throughput is one pixel per clock with no stalls and no backpressure.
- Reset values:
  - R, G, B = 0; de_out = 0; sync_out = 0
  - map_addr = 0; sx = sy = 0
  - all pipeline valid bits = 0
  - palette = reset contents
- Reset mid-frame flushes the pipeline. Outputs stay 0 for L cycles after rst deasserts, then track the input with latency L.
- frame_start coincident with rst: reset wins and the shadows are 0.
- frame_start while vde = 1 still latches. Pixels already in S0 or later use the old shadows.

## Test plan
- Reset: hold rst 3 cycles, then drive vde=1 with map_data=2 and every rom_data pixel = 2 → first de_out at cycle L after vde, RGB = 00FF00. Before that cycle RGB = 0 and de_out = 0.
- Latency/pixel select: x=H_START, y=V_START, sx=sy=0, map_data=3, rom_data top PIX_W bits = 4 → map_addr=0 at t+1, rom_addr={3,0} at t+2, RGB=FF0000 with de_out=1 exactly at t+4.
- Transparency/palette: pixel 0 → FFFFFF. Pulse pal_we with pal_addr=0, pal_wdata=123456 → the next transparent pixel reads 123456; the write cycle itself reads FFFFFF.
- Scroll wrap: frame_start with scroll_x=2040, then x=H_START+10 → lx=2, map_addr column 0, col-in-tile 2.
- Shadowing: change scroll_y from 0 to 64 mid-frame → map_addr row is unchanged until the next frame_start, then row +2.
- Out-of-range: vde=1 with x−H_START=1920 → RGB=0 and de_out=1 at t+L. With vde=0 → de_out=0 and sync_out equals sync_in delayed by L.
